hs_bus_amba_axi_wr_sub: RTL and testbench

AXI4 write-channel subordinate (responder) that terminates AW/W/B traffic from a manager and drives a simple single-port SRAM-style write port. It decodes AxBURST, AxSIZE and AxLEN, generates per-beat addresses, and returns BRESP using the bresp_2b_e and axburst_e encodings from hs_bus_amba_axi_typedefs_pkg. It holds one outstanding write. It sits at the leaf of the interconnect, in front of register files and scratch memories.

---
 rtl/hs_bus_amba_axi_wr_sub.sv | 188 ++++++++++++++++++
 tb/tb_hs_bus_amba_axi_wr_sub.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_bus_amba_axi_wr_sub.sv
// AXI4 write-channel subordinate. It accepts one AW/W/B transaction at a time
// and turns the accepted W beats into writes on a single-port SRAM-style port.
//
// The shared AXI encodings live in the package at the top of this file, so
// the block compiles on its own.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   aw*  (id/addr/len/size/burst/valid/ready)   write address channel
//   w*   (data/strb/last/valid/ready)           write data channel
//   b*   (id/resp/valid/ready)                  write response channel
//   mem_we/mem_addr/mem_wdata/mem_wstrb         registered memory write port
//                                               (1-cycle write latency)

package hs_bus_amba_axi_typedefs_pkg;
  typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} bresp_2b_e;
  typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RESERVED = 2'b11} axburst_e;

  // AxSIZE encoding of a full-width beat on a data bus of the given width.
  function automatic logic [2:0] get_axsize(input int unsigned data_width);
    return 3'($clog2(data_width / 8));
  endfunction
endpackage

module hs_bus_amba_axi_wr_sub
  import hs_bus_amba_axi_typedefs_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ID_WIDTH-1:0]       awid,
  input  logic [ADDR_WIDTH-1:0]     awaddr,
  input  logic [7:0]                awlen,
  input  logic [2:0]                awsize,
  input  axburst_e                  awburst,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      wlast,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [ID_WIDTH-1:0]       bid,
  output bresp_2b_e                 bresp,
  output logic                      bvalid,
  input  logic                      bready,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH/8-1:0]   mem_wstrb
);
  localparam int OFF_W = $clog2(DATA_WIDTH / 8);
  localparam int DEC_W = MEM_ADDR_WIDTH + OFF_W;
  localparam logic [2:0] MAX_SIZE = get_axsize(DATA_WIDTH);
  // Address bits above the decoded byte range; all-zero when the range covers the bus.
  localparam logic [ADDR_WIDTH-1:0] HI_MASK = ~((ADDR_WIDTH'(1) << DEC_W) - ADDR_WIDTH'(1));

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_e;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;   // current beat address, advanced per beat
    logic [7:0]            len;
    logic [2:0]            size;
    axburst_e              burst;
  } aw_req_t;

  state_e    state, state_nxt;
  aw_req_t   aw_q;
  logic [7:0] cnt_q;
  bresp_2b_e err_q, aw_err, beat_err;
  logic      aw_hs, w_hs;

  // ---------------- AW classification ----------------
  // 4KB check uses the size-aligned start offset within the page
  // (assumes ADDR_WIDTH >= 12).
  logic [11:0] aw_smask;
  logic [16:0] aw_end;
  logic        aw_cross;
  assign aw_smask = 12'((13'd1 << awsize) - 13'd1);
  assign aw_end   = 17'(awaddr[11:0] & ~aw_smask) + ((17'(awlen) + 17'd1) << awsize);
  assign aw_cross = aw_end > 17'd4096;

  always_comb begin
    aw_err = OKAY;
    if ((awaddr & HI_MASK) != '0)
      aw_err = DECERR;
    else if (awsize > MAX_SIZE || awburst == RESERVED ||
             (awburst == WRAP && !(awlen inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
             (awburst == INCR && aw_cross))
      aw_err = SLVERR;
  end

  // ---------------- beat address generation ----------------
  logic [ADDR_WIDTH-1:0] step, addr_al, addr_inc, wrap_msk, addr_nxt;
  assign step     = ADDR_WIDTH'(1) << aw_q.size;
  assign addr_al  = aw_q.addr & ~(step - ADDR_WIDTH'(1));
  assign addr_inc = addr_al + step;
  assign wrap_msk = ((ADDR_WIDTH'(aw_q.len) + ADDR_WIDTH'(1)) << aw_q.size) - ADDR_WIDTH'(1);

  always_comb begin
    addr_nxt = addr_inc;
    case (aw_q.burst)
      FIXED:   addr_nxt = aw_q.addr;
      WRAP:    addr_nxt = (addr_al & ~wrap_msk) | (addr_inc & wrap_msk);
      default: addr_nxt = addr_inc;
    endcase
  end

  // Length mismatch turns the response into SLVERR (DECERR is kept). Once a
  // beat at count==len arrives without wlast the error sticks, so every later
  // beat up to wlast is consumed with the write suppressed.
  always_comb begin
    beat_err = err_q;
    if (err_q != DECERR) begin
      if (wlast && cnt_q != aw_q.len)       beat_err = SLVERR;
      else if (!wlast && cnt_q == aw_q.len) beat_err = SLVERR;
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    case (state)
      IDLE: begin
        awready = ~rst;
        if (awvalid && !rst) state_nxt = DATA;
      end
      DATA: begin
        wready = 1'b1;
        if (wvalid && wlast) state_nxt = RESP;
      end
      RESP: begin
        bvalid = 1'b1;
        if (bready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign bid   = aw_q.id;
  assign bresp = err_q;

  // ---------------- datapath / memory port ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_q      <= '0;
      cnt_q     <= '0;
      err_q     <= OKAY;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      mem_we <= 1'b0;
      if (aw_hs) begin
        aw_q  <= '{id: awid, addr: awaddr, len: awlen, size: awsize, burst: awburst};
        cnt_q <= '0;
        err_q <= aw_err;
      end
      if (w_hs) begin
        cnt_q     <= cnt_q + 8'd1;
        aw_q.addr <= addr_nxt;
        err_q     <= beat_err;
        if (err_q == OKAY) begin
          mem_we    <= 1'b1;
          mem_addr  <= MEM_ADDR_WIDTH'(aw_q.addr >> OFF_W);
          mem_wdata <= wdata;
          mem_wstrb <= wstrb;
        end
      end
    end
  end
endmodule

// File: tb/tb_hs_bus_amba_axi_wr_sub.sv
// Bench for hs_bus_amba_axi_wr_sub: a table of bursts with expected write
// counts and responses, a scoreboard of expected memory writes and B
// responses, and hand-written sequences for B backpressure and mid-burst reset.
module tb_hs_bus_amba_axi_wr_sub;
  import hs_bus_amba_axi_typedefs_pkg::*;

  localparam int AW = 32, DW = 32, IW = 4, MW = 10, SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] awid;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  axburst_e      awburst;
  logic          awvalid, awready;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          wlast, wvalid, wready;
  logic [IW-1:0] bid;
  bresp_2b_e     bresp;
  logic          bvalid, bready;
  logic          mem_we;
  logic [MW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;

  always #5 clk = ~clk;

  hs_bus_amba_axi_wr_sub #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_ADDR_WIDTH(MW)) dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );

  int n_tests = 0, n_fail = 0;

  typedef struct {
    logic [MW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } wr_t;
  typedef struct {
    logic [IW-1:0] id;
    logic [1:0]    resp;
  } b_t;
  typedef struct {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
    int            nbeats;  // beats driven; wlast on the final one
    int            nwr;     // leading beats expected to reach memory
    logic [1:0]    resp;
  } vec_t;

  wr_t  wr_q[$];
  b_t   b_q[$];
  wr_t  mw;
  b_t   mb;
  logic hs_prev = 1'b0;
  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference beat address, written from the burst definition.
  function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] a, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst, input int i);
    longint unsigned step, blk, base, sa;
    step = longint'(1) << size;
    sa   = longint'(a);
    case (burst)
      2'd0: return a;
      2'd2: begin
        blk  = (longint'(len) + 1) * step;
        base = (sa / blk) * blk;
        return AW'(base + ((sa - base) + longint'(i) * step) % blk);
      end
      default: return (i == 0) ? a : AW'((sa / step) * step + longint'(i) * step);
    endcase
  endfunction

  // Scoreboard monitor: values sampled on the negedge describe the handshake
  // that happens on the following posedge.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      check("wr_latency", {63'd0, hs_prev}, 64'd1);
      if (wr_q.size() == 0) check("spurious_write", {63'd0, mem_we}, 64'd0);
      else begin
        mw = wr_q.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(mw.addr));
        check("wr_strb_data", 64'({mem_wstrb, mem_wdata}), 64'({mw.strb, mw.data}));
      end
    end
    if (bvalid === 1'b1 && bready === 1'b1) begin
      if (b_q.size() == 0) check("spurious_b", {63'd0, bvalid}, 64'd0);
      else begin
        mb = b_q.pop_front();
        check("b_id", 64'(bid), 64'(mb.id));
        check("b_resp", 64'(bresp), 64'(mb.resp));
      end
    end
    hs_prev = (wvalid === 1'b1) && (wready === 1'b1) && (rst === 1'b0);
  end

  // Drive AW plus nbeats W beats; push expectations for the first nwr writes.
  // stop_after >= 0 leaves the beat with that index on the bus and returns.
  task automatic send_burst(input vec_t v, input int stop_after);
    logic [DW-1:0] d[$];
    logic [SW-1:0] s[$];
    wr_t e;
    int t;
    for (int i = 0; i < v.nbeats; i++) begin
      d.push_back($urandom);
      s.push_back(SW'($urandom));
    end
    for (int i = 0; i < v.nwr; i++) begin
      e.addr = MW'(exp_addr(v.addr, v.len, v.size, v.burst, i) >> 2);
      e.data = d[i];
      e.strb = s[i];
      wr_q.push_back(e);
    end
    if (stop_after < 0) b_q.push_back('{id: v.id, resp: v.resp});
    @(negedge clk);
    awid = v.id; awaddr = v.addr; awlen = v.len; awsize = v.size;
    awburst = axburst_e'(v.burst); awvalid = 1'b1;
    t = 0;
    while (!awready && t < 50) begin @(negedge clk); t++; end
    if (!awready) begin check("aw_timeout", {63'd0, awready}, 64'd1); awvalid = 1'b0; return; end
    @(posedge clk); #1 awvalid = 1'b0;
    for (int i = 0; i < v.nbeats; i++) begin
      wdata = d[i]; wstrb = s[i]; wlast = (i == v.nbeats - 1); wvalid = 1'b1;
      if (i == stop_after) return;
      @(negedge clk);
      t = 0;
      while (!wready && t < 50) begin @(negedge clk); t++; end
      if (!wready) begin check("w_timeout", {63'd0, wready}, 64'd1); wvalid = 1'b0; return; end
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic wait_b();
    int t = 0;
    while (b_q.size() != 0 && t < 100) begin @(negedge clk); t++; end
    if (b_q.size() != 0) begin check("b_timeout", 64'(b_q.size()), 64'd0); b_q.delete(); end
    check("wr_drained", 64'(wr_q.size()), 64'd0);
    wr_q.delete();
  endtask

  initial begin
    vec_t v;
    int t;
    rst = 1'b1; awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = FIXED; wdata = '0; wstrb = '0;

    //          id     addr        len   size  burst nbeats nwr resp
    vecs[0]  = '{4'd3,  32'h10,   8'd0,  3'd2, 2'd1, 1,  1, 2'd0};  // single INCR
    vecs[1]  = '{4'd5,  32'h18,   8'd3,  3'd2, 2'd2, 4,  4, 2'd0};  // WRAP 6,7,4,5
    vecs[2]  = '{4'd1,  32'h20,   8'd1,  3'd2, 2'd3, 2,  0, 2'd2};  // RESERVED burst
    vecs[3]  = '{4'd2,  32'h1000, 8'd0,  3'd2, 2'd1, 1,  0, 2'd3};  // out of range
    vecs[4]  = '{4'd7,  32'h1000, 8'd0,  3'd3, 2'd1, 1,  0, 2'd3};  // DECERR beats bad size
    vecs[5]  = '{4'd9,  32'h0,    8'd3,  3'd2, 2'd1, 2,  2, 2'd2};  // early wlast
    vecs[6]  = '{4'd4,  32'h21,   8'd2,  3'd2, 2'd1, 3,  3, 2'd0};  // unaligned INCR
    vecs[7]  = '{4'd6,  32'h5,    8'd3,  3'd0, 2'd1, 4,  4, 2'd0};  // byte INCR
    vecs[8]  = '{4'd8,  32'h40,   8'd2,  3'd2, 2'd0, 3,  3, 2'd0};  // FIXED
    vecs[9]  = '{4'd10, 32'h80,   8'd2,  3'd2, 2'd2, 3,  0, 2'd2};  // WRAP len 2
    vecs[10] = '{4'd11, 32'hFF8,  8'd3,  3'd2, 2'd1, 4,  0, 2'd2};  // 4KB crossing
    vecs[11] = '{4'd12, 32'h100,  8'd1,  3'd2, 2'd1, 4,  2, 2'd2};  // wlast late
    vecs[12] = '{4'd13, 32'h0,    8'd0,  3'd3, 2'd1, 1,  0, 2'd2};  // size > bus
    vecs[13] = '{4'd14, 32'h4,    8'd1,  3'd2, 2'd2, 2,  2, 2'd0};  // WRAP len 1
    vecs[14] = '{4'd15, 32'h3FE,  8'd1,  3'd1, 2'd1, 2,  2, 2'd0};  // halfword INCR
    vecs[15] = '{4'd0,  32'h104,  8'd15, 3'd2, 2'd2, 16, 16, 2'd0}; // WRAP len 15

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", {63'd0, awready}, 64'd0);
    check("rst_wready", {63'd0, wready}, 64'd0);
    check("rst_bvalid", {63'd0, bvalid}, 64'd0);
    check("rst_bid", 64'(bid), 64'd0);
    check("rst_bresp", 64'(bresp), 64'(OKAY));
    check("rst_mem_we", {63'd0, mem_we}, 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("idle_awready", {63'd0, awready}, 64'd1);

    for (int k = 0; k < 16; k++) begin
      send_burst(vecs[k], -1);
      wait_b();
    end

    // B backpressure: response held, no new AW accepted
    bready = 1'b0;
    v = '{4'd9, 32'h30, 8'd1, 3'd2, 2'd1, 2, 2, 2'd0};
    send_burst(v, -1);
    t = 0;
    while (!bvalid && t < 50) begin @(negedge clk); t++; end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold_bvalid", {63'd0, bvalid}, 64'd1);
      check("hold_bid", 64'(bid), 64'd9);
      check("hold_bresp", 64'(bresp), 64'(OKAY));
      check("hold_awready", {63'd0, awready}, 64'd0);
    end
    bready = 1'b1;
    wait_b();

    // Reset during beat 2 of a 4-beat INCR: beats 0,1 written, nothing after
    v = '{4'd3, 32'h200, 8'd3, 3'd2, 2'd1, 4, 2, 2'd0};
    send_burst(v, 2);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; wvalid = 1'b0; wlast = 1'b0;
    @(negedge clk);
    check("post_rst_awready", {63'd0, awready}, 64'd1);
    for (int c = 0; c < 3; c++) begin
      check("post_rst_mem_we", {63'd0, mem_we}, 64'd0);
      check("post_rst_bvalid", {63'd0, bvalid}, 64'd0);
      @(negedge clk);
    end
    check("rst_wr_drained", 64'(wr_q.size()), 64'd0);

    // Normal operation resumes after the abandoned burst
    send_burst(vecs[1], -1);
    wait_b();

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
